// File: rtl/rob_dual_commit_pkg.sv
// Shared definitions for the dual-commit reorder buffer: instruction class
// encodings carried with each entry and fixed field widths.
package rob_dual_commit_pkg;

    localparam int unsigned SIG_W = 3;
    localparam int unsigned RD_W  = 5;

    typedef enum logic [SIG_W-1:0] {
        DEFAULT = 3'd0,
        NORMAL  = 3'd1,
        BRANCH  = 3'd2,
        LOAD    = 3'd3,
        STORE   = 3'd4
    } sig_t;

endpackage

// File: rtl/rob_operand_lookup.sv
// Combinational operand lookup: a ready ROB entry first, otherwise the
// lowest-numbered writeback lane that is broadcasting the requested id.
module rob_operand_lookup
    import rob_dual_commit_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ID_W     = 5,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WB_PORTS = 2
) (
    input  logic [ID_W-1:0]                    q,
    input  logic [DEPTH-1:0]                   ready,
    input  logic [DEPTH-1:0][XLEN-1:0]         values,
    input  logic [WB_PORTS-1:0][ID_W-1:0]      wb_dest,
    input  logic [WB_PORTS-1:0][XLEN-1:0]      wb_value,
    output logic                               valid,
    output logic [XLEN-1:0]                    v
);

    always_comb begin
        valid = 1'b0;
        v     = '0;
        if (q != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!valid && ready[i] && q == ID_W'(i + 1)) begin
                    valid = 1'b1;
                    v     = values[i];
                end
            end
            // Forward scan with a first-hit guard so the lowest lane wins.
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (!valid && wb_dest[p] == q) begin
                    valid = 1'b1;
                    v     = wb_value[p];
                end
            end
        end
    end

endmodule

// File: rtl/rob_dual_commit.sv
// Reorder buffer with in-order allocation, multi-lane writeback, operand
// forwarding and up to two retirements per cycle.
module rob_dual_commit
    import rob_dual_commit_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ID_W     = 5,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WB_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rdy,
    output logic                               is_full,
    input  logic                               valid_from_issuer,
    input  logic [SIG_W-1:0]                   signal_from_issuer,
    input  logic [RD_W-1:0]                    rd_from_issuer,
    input  logic [XLEN-1:0]                    pc_from_issuer,
    input  logic [XLEN-1:0]                    next_pc_from_issuer,
    output logic [ID_W-1:0]                    dest_to_issuer,
    input  logic [ID_W-1:0]                    qj,
    input  logic [ID_W-1:0]                    qk,
    output logic                               valid_of_vj,
    output logic                               valid_of_vk,
    output logic [XLEN-1:0]                    vj,
    output logic [XLEN-1:0]                    vk,
    input  logic [WB_PORTS-1:0][ID_W-1:0]      wb_dest,
    input  logic [WB_PORTS-1:0][XLEN-1:0]      wb_value,
    input  logic [WB_PORTS-1:0][XLEN-1:0]      wb_next_pc,
    input  logic                               reset_from_rob_bus,
    output logic                               reset_to_rob_bus,
    output logic [XLEN-1:0]                    next_pc_to_rob_bus,
    output logic                               br_to_rob_bus,
    output logic                               is_taken_to_rob_bus,
    output logic [XLEN-1:0]                    pc_to_rob_bus,
    output logic [ID_W-1:0]                    dest_to_rob_bus,
    output logic                               ls_select_to_rob_bus,
    output logic [ID_W-1:0]                    commit_dest0,
    output logic [ID_W-1:0]                    commit_dest1,
    output logic [RD_W-1:0]                    commit_rd0,
    output logic [RD_W-1:0]                    commit_rd1,
    output logic [XLEN-1:0]                    commit_value0,
    output logic [XLEN-1:0]                    commit_value1
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]            head, tail, count;
    sig_t                       sig_q  [DEPTH];
    logic [DEPTH-1:0]           ready_q;
    logic [DEPTH-1:0][XLEN-1:0] value_q;
    logic [RD_W-1:0]            rd_q   [DEPTH];
    logic [XLEN-1:0]            pc_q   [DEPTH];
    logic [XLEN-1:0]            pred_q [DEPTH];
    logic [XLEN-1:0]            act_q  [DEPTH];

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(DEPTH)) ? ID_W'(1) : id + ID_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ID_W-1:0] id);
        return IDX_W'(id - ID_W'(1));
    endfunction

    logic [ID_W-1:0]  head1;
    logic [IDX_W-1:0] h0, h1, t0;
    sig_t             s0_sig, s1_sig;
    logic             commit0, commit1, load_wait, accept;

    assign is_full        = (count == ID_W'(DEPTH));
    assign dest_to_issuer = tail;

    always_comb begin
        head1     = next_id(head);
        h0        = to_idx(head);
        h1        = to_idx(head1);
        t0        = to_idx(tail);
        s0_sig    = sig_q[h0];
        s1_sig    = sig_q[h1];
        accept    = valid_from_issuer && !is_full;
        commit0   = (count != '0) && (s0_sig == STORE || ready_q[h0]);
        // Branches and stores retire alone from slot 0 so their bus outputs stay unambiguous.
        commit1   = commit0 && (count >= ID_W'(2)) && ready_q[h1]
                    && s0_sig != BRANCH && s0_sig != STORE
                    && s1_sig != STORE && s1_sig != BRANCH;
        load_wait = (count != '0) && s0_sig == LOAD && !ready_q[h0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head                 <= ID_W'(1);
            tail                 <= ID_W'(1);
            count                <= '0;
            ready_q              <= '0;
            value_q              <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sig_q[i]  <= DEFAULT;
                rd_q[i]   <= '0;
                pc_q[i]   <= '0;
                pred_q[i] <= '0;
                act_q[i]  <= '0;
            end
            reset_to_rob_bus     <= 1'b0;
            next_pc_to_rob_bus   <= '0;
            br_to_rob_bus        <= 1'b0;
            is_taken_to_rob_bus  <= 1'b0;
            pc_to_rob_bus        <= '0;
            dest_to_rob_bus      <= '0;
            ls_select_to_rob_bus <= 1'b0;
            commit_dest0         <= '0;
            commit_dest1         <= '0;
            commit_rd0           <= '0;
            commit_rd1           <= '0;
            commit_value0        <= '0;
            commit_value1        <= '0;
        end else if (rdy) begin
            reset_to_rob_bus     <= 1'b0;
            next_pc_to_rob_bus   <= '0;
            br_to_rob_bus        <= 1'b0;
            is_taken_to_rob_bus  <= 1'b0;
            pc_to_rob_bus        <= '0;
            dest_to_rob_bus      <= '0;
            ls_select_to_rob_bus <= 1'b0;
            commit_dest0         <= '0;
            commit_dest1         <= '0;
            commit_rd0           <= '0;
            commit_rd1           <= '0;
            commit_value0        <= '0;
            commit_value1        <= '0;
            if (reset_from_rob_bus) begin
                head    <= ID_W'(1);
                tail    <= ID_W'(1);
                count   <= '0;
                ready_q <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) sig_q[i] <= DEFAULT;
            end else begin
                if (commit0) begin
                    ready_q[h0] <= 1'b0;
                    sig_q[h0]   <= DEFAULT;
                    if (s0_sig == STORE) begin
                        dest_to_rob_bus      <= head;
                        ls_select_to_rob_bus <= 1'b1;
                    end else begin
                        commit_dest0  <= head;
                        commit_rd0    <= rd_q[h0];
                        commit_value0 <= value_q[h0];
                    end
                    if (s0_sig == BRANCH) begin
                        br_to_rob_bus       <= 1'b1;
                        pc_to_rob_bus       <= pc_q[h0];
                        is_taken_to_rob_bus <= (act_q[h0] != pc_q[h0] + XLEN'(4));
                        if (pred_q[h0] != act_q[h0]) begin
                            reset_to_rob_bus   <= 1'b1;
                            next_pc_to_rob_bus <= act_q[h0];
                        end
                    end
                end else if (load_wait) begin
                    dest_to_rob_bus      <= head;
                    ls_select_to_rob_bus <= 1'b0;
                end
                if (commit1) begin
                    ready_q[h1]   <= 1'b0;
                    sig_q[h1]     <= DEFAULT;
                    commit_dest1  <= head1;
                    commit_rd1    <= rd_q[h1];
                    commit_value1 <= value_q[h1];
                end
                head <= commit1 ? next_id(head1) : (commit0 ? head1 : head);
                if (accept) begin
                    sig_q[t0]   <= sig_t'(signal_from_issuer);
                    ready_q[t0] <= 1'b0;
                    rd_q[t0]    <= rd_from_issuer;
                    pc_q[t0]    <= pc_from_issuer;
                    pred_q[t0]  <= next_pc_from_issuer;
                    tail        <= next_id(tail);
                end
                for (int unsigned p = 0; p < WB_PORTS; p++) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (wb_dest[p] != '0 && wb_dest[p] == ID_W'(i + 1)) begin
                            ready_q[i] <= 1'b1;
                            value_q[i] <= wb_value[p];
                            act_q[i]   <= wb_next_pc[p];
                        end
                    end
                end
                count <= count + ID_W'(accept) - ID_W'(commit0) - ID_W'(commit1);
            end
        end
    end

    rob_operand_lookup #(
        .DEPTH    (DEPTH),
        .ID_W     (ID_W),
        .XLEN     (XLEN),
        .WB_PORTS (WB_PORTS)
    ) u_lookup_j (
        .q        (qj),
        .ready    (ready_q),
        .values   (value_q),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .valid    (valid_of_vj),
        .v        (vj)
    );

    rob_operand_lookup #(
        .DEPTH    (DEPTH),
        .ID_W     (ID_W),
        .XLEN     (XLEN),
        .WB_PORTS (WB_PORTS)
    ) u_lookup_k (
        .q        (qk),
        .ready    (ready_q),
        .values   (value_q),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .valid    (valid_of_vk),
        .v        (vk)
    );

endmodule

// File: tb/tb_rob_dual_commit.sv
// Directed bench for rob_dual_commit: dual retire, full/wrap, branch
// mispredict with flush, stores, load release, lookup priority, async reset.
module tb_rob_dual_commit;
    import rob_dual_commit_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned ID_W  = 5;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned WBP   = 2;

    logic clk = 1'b0;
    logic rst, rdy;
    logic is_full;
    logic valid_from_issuer;
    logic [SIG_W-1:0] signal_from_issuer;
    logic [RD_W-1:0] rd_from_issuer;
    logic [XLEN-1:0] pc_from_issuer, next_pc_from_issuer;
    logic [ID_W-1:0] dest_to_issuer;
    logic [ID_W-1:0] qj, qk;
    logic valid_of_vj, valid_of_vk;
    logic [XLEN-1:0] vj, vk;
    logic [WBP-1:0][ID_W-1:0] wb_dest;
    logic [WBP-1:0][XLEN-1:0] wb_value, wb_next_pc;
    logic reset_from_rob_bus, reset_to_rob_bus;
    logic [XLEN-1:0] next_pc_to_rob_bus;
    logic br_to_rob_bus, is_taken_to_rob_bus;
    logic [XLEN-1:0] pc_to_rob_bus;
    logic [ID_W-1:0] dest_to_rob_bus;
    logic ls_select_to_rob_bus;
    logic [ID_W-1:0] commit_dest0, commit_dest1;
    logic [RD_W-1:0] commit_rd0, commit_rd1;
    logic [XLEN-1:0] commit_value0, commit_value1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_dual_commit #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN), .WB_PORTS(WBP)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .is_full(is_full),
        .valid_from_issuer(valid_from_issuer), .signal_from_issuer(signal_from_issuer),
        .rd_from_issuer(rd_from_issuer), .pc_from_issuer(pc_from_issuer),
        .next_pc_from_issuer(next_pc_from_issuer), .dest_to_issuer(dest_to_issuer),
        .qj(qj), .qk(qk), .valid_of_vj(valid_of_vj), .valid_of_vk(valid_of_vk),
        .vj(vj), .vk(vk), .wb_dest(wb_dest), .wb_value(wb_value), .wb_next_pc(wb_next_pc),
        .reset_from_rob_bus(reset_from_rob_bus), .reset_to_rob_bus(reset_to_rob_bus),
        .next_pc_to_rob_bus(next_pc_to_rob_bus), .br_to_rob_bus(br_to_rob_bus),
        .is_taken_to_rob_bus(is_taken_to_rob_bus), .pc_to_rob_bus(pc_to_rob_bus),
        .dest_to_rob_bus(dest_to_rob_bus), .ls_select_to_rob_bus(ls_select_to_rob_bus),
        .commit_dest0(commit_dest0), .commit_dest1(commit_dest1),
        .commit_rd0(commit_rd0), .commit_rd1(commit_rd1),
        .commit_value0(commit_value0), .commit_value1(commit_value1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_from_issuer   = 1'b0;
        signal_from_issuer  = '0;
        rd_from_issuer      = '0;
        pc_from_issuer      = '0;
        next_pc_from_issuer = '0;
        wb_dest             = '0;
        wb_value            = '0;
        wb_next_pc          = '0;
        reset_from_rob_bus  = 1'b0;
        qj                  = '0;
        qk                  = '0;
    endtask

    task automatic alloc(input logic [SIG_W-1:0] s, input logic [RD_W-1:0] r,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] np);
        valid_from_issuer   = 1'b1;
        signal_from_issuer  = s;
        rd_from_issuer      = r;
        pc_from_issuer      = p;
        next_pc_from_issuer = np;
        tick();
        valid_from_issuer   = 1'b0;
    endtask

    task automatic do_flush();
        reset_from_rob_bus = 1'b1;
        tick();
        reset_from_rob_bus = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL reset_commit_dest0: got %0d expected 0", commit_dest0); end
        checks++; if (commit_dest1 !== 5'd0) begin errors++; $display("FAIL reset_commit_dest1: got %0d expected 0", commit_dest1); end
        checks++; if (reset_to_rob_bus !== 1'b0) begin errors++; $display("FAIL reset_reset_to: got %0b expected 0", reset_to_rob_bus); end
        checks++; if (br_to_rob_bus !== 1'b0) begin errors++; $display("FAIL reset_br: got %0b expected 0", br_to_rob_bus); end
        checks++; if (dest_to_rob_bus !== 5'd0) begin errors++; $display("FAIL reset_dest_bus: got %0d expected 0", dest_to_rob_bus); end
        checks++; if (is_full !== 1'b0) begin errors++; $display("FAIL reset_is_full: got %0b expected 0", is_full); end
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL reset_tail: got %0d expected 1", dest_to_issuer); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dual_commit();
        alloc(NORMAL, 5'd3, 32'h10, 32'h14);
        alloc(NORMAL, 5'd4, 32'h14, 32'h18);
        alloc(NORMAL, 5'd5, 32'h18, 32'h1c);
        checks++; if (dest_to_issuer !== 5'd4) begin errors++; $display("FAIL dual_tail: got %0d expected 4", dest_to_issuer); end
        wb_dest[0] = 5'd2; wb_value[0] = 32'd7;
        tick();
        wb_dest[0] = 5'd1; wb_value[0] = 32'd5;
        tick();
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL dual_early: got %0d expected 0", commit_dest0); end
        wb_dest = '0;
        tick();
        checks++; if (commit_dest0 !== 5'd1) begin errors++; $display("FAIL dual_dest0: got %0d expected 1", commit_dest0); end
        checks++; if (commit_rd0 !== 5'd3) begin errors++; $display("FAIL dual_rd0: got %0d expected 3", commit_rd0); end
        checks++; if (commit_value0 !== 32'd5) begin errors++; $display("FAIL dual_value0: got %0h expected 5", commit_value0); end
        checks++; if (commit_dest1 !== 5'd2) begin errors++; $display("FAIL dual_dest1: got %0d expected 2", commit_dest1); end
        checks++; if (commit_rd1 !== 5'd4) begin errors++; $display("FAIL dual_rd1: got %0d expected 4", commit_rd1); end
        checks++; if (commit_value1 !== 32'd7) begin errors++; $display("FAIL dual_value1: got %0h expected 7", commit_value1); end
        tick();
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL dual_id3_pending: got %0d expected 0", commit_dest0); end
        do_flush();
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL dual_flush_tail: got %0d expected 1", dest_to_issuer); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 16; i++) alloc(NORMAL, 5'(i + 1), 32'(i * 4), 32'(i * 4 + 4));
        checks++; if (is_full !== 1'b1) begin errors++; $display("FAIL full_is_full: got %0b expected 1", is_full); end
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL full_tail_wrap: got %0d expected 1", dest_to_issuer); end
        alloc(NORMAL, 5'd17, 32'h40, 32'h44);
        checks++; if (is_full !== 1'b1) begin errors++; $display("FAIL full_17th_is_full: got %0b expected 1", is_full); end
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL full_17th_ignored: got %0d expected 1", dest_to_issuer); end
        wb_dest[0] = 5'd1; wb_value[0] = 32'h11;
        wb_dest[1] = 5'd2; wb_value[1] = 32'h22;
        tick();
        wb_dest = '0;
        tick();
        checks++; if (commit_dest0 !== 5'd1 || commit_value0 !== 32'h11) begin errors++; $display("FAIL full_retire0: got %0d/%0h expected 1/11", commit_dest0, commit_value0); end
        checks++; if (commit_dest1 !== 5'd2 || commit_value1 !== 32'h22) begin errors++; $display("FAIL full_retire1: got %0d/%0h expected 2/22", commit_dest1, commit_value1); end
        checks++; if (is_full !== 1'b0) begin errors++; $display("FAIL full_after_retire: got %0b expected 0", is_full); end
        alloc(NORMAL, 5'd9, 32'h80, 32'h84);
        checks++; if (dest_to_issuer !== 5'd2) begin errors++; $display("FAIL full_wrap_id1: got %0d expected 2", dest_to_issuer); end
        wb_dest[0] = 5'd3; wb_value[0] = 32'h33;
        tick();
        wb_dest = '0;
        alloc(NORMAL, 5'd10, 32'h84, 32'h88);
        checks++; if (commit_dest0 !== 5'd3 || commit_dest1 !== 5'd0) begin errors++; $display("FAIL full_alloc_commit: got %0d/%0d expected 3/0", commit_dest0, commit_dest1); end
        checks++; if (is_full !== 1'b0 || dest_to_issuer !== 5'd3) begin errors++; $display("FAIL full_count_held: got full=%0b tail=%0d expected 0/3", is_full, dest_to_issuer); end
        alloc(NORMAL, 5'd11, 32'h88, 32'h8c);
        checks++; if (is_full !== 1'b1 || dest_to_issuer !== 5'd4) begin errors++; $display("FAIL full_refill: got full=%0b tail=%0d expected 1/4", is_full, dest_to_issuer); end
        do_flush();
        checks++; if (is_full !== 1'b0 || dest_to_issuer !== 5'd1) begin errors++; $display("FAIL full_flush: got full=%0b tail=%0d expected 0/1", is_full, dest_to_issuer); end
    endtask

    task automatic test_branch_mispredict();
        alloc(BRANCH, 5'd0, 32'h100, 32'h104);
        alloc(NORMAL, 5'd6, 32'h104, 32'h108);
        wb_dest[0] = 5'd1; wb_value[0] = 32'h0;  wb_next_pc[0] = 32'h200;
        wb_dest[1] = 5'd2; wb_value[1] = 32'h66; wb_next_pc[1] = 32'h108;
        tick();
        wb_dest = '0; wb_next_pc = '0;
        tick();
        checks++; if (reset_to_rob_bus !== 1'b1) begin errors++; $display("FAIL br_reset_pulse: got %0b expected 1", reset_to_rob_bus); end
        checks++; if (next_pc_to_rob_bus !== 32'h200) begin errors++; $display("FAIL br_next_pc: got %0h expected 200", next_pc_to_rob_bus); end
        checks++; if (br_to_rob_bus !== 1'b1 || is_taken_to_rob_bus !== 1'b1) begin errors++; $display("FAIL br_taken: got br=%0b taken=%0b expected 1/1", br_to_rob_bus, is_taken_to_rob_bus); end
        checks++; if (pc_to_rob_bus !== 32'h100) begin errors++; $display("FAIL br_pc: got %0h expected 100", pc_to_rob_bus); end
        checks++; if (commit_dest1 !== 5'd0) begin errors++; $display("FAIL br_slot1_blocked: got %0d expected 0", commit_dest1); end
        do_flush();
        checks++; if (reset_to_rob_bus !== 1'b0) begin errors++; $display("FAIL br_pulse_one_cycle: got %0b expected 0", reset_to_rob_bus); end
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL br_flush_wins: got %0d expected 0", commit_dest0); end
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL br_flush_tail: got %0d expected 1", dest_to_issuer); end
    endtask

    task automatic test_store();
        alloc(STORE, 5'd0, 32'h200, 32'h204);
        alloc(STORE, 5'd0, 32'h204, 32'h208);
        checks++; if (dest_to_rob_bus !== 5'd1 || ls_select_to_rob_bus !== 1'b1) begin errors++; $display("FAIL st_first: got %0d/%0b expected 1/1", dest_to_rob_bus, ls_select_to_rob_bus); end
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL st_ports_idle: got %0d expected 0", commit_dest0); end
        tick();
        checks++; if (dest_to_rob_bus !== 5'd2 || ls_select_to_rob_bus !== 1'b1) begin errors++; $display("FAIL st_second: got %0d/%0b expected 2/1", dest_to_rob_bus, ls_select_to_rob_bus); end
        tick();
        checks++; if (dest_to_rob_bus !== 5'd0 || ls_select_to_rob_bus !== 1'b0) begin errors++; $display("FAIL st_return_zero: got %0d/%0b expected 0/0", dest_to_rob_bus, ls_select_to_rob_bus); end
    endtask

    task automatic test_load_release();
        alloc(LOAD, 5'd7, 32'h300, 32'h304);
        tick();
        checks++; if (dest_to_rob_bus !== 5'd3 || ls_select_to_rob_bus !== 1'b0) begin errors++; $display("FAIL ld_release: got %0d/%0b expected 3/0", dest_to_rob_bus, ls_select_to_rob_bus); end
        checks++; if (commit_dest0 !== 5'd0) begin errors++; $display("FAIL ld_no_retire: got %0d expected 0", commit_dest0); end
        wb_dest[0] = 5'd3; wb_value[0] = 32'h99;
        tick();
        wb_dest = '0;
        tick();
        checks++; if (commit_dest0 !== 5'd3 || commit_rd0 !== 5'd7 || commit_value0 !== 32'h99) begin errors++; $display("FAIL ld_commit: got %0d/%0d/%0h expected 3/7/99", commit_dest0, commit_rd0, commit_value0); end
        checks++; if (dest_to_rob_bus !== 5'd0) begin errors++; $display("FAIL ld_bus_clear: got %0d expected 0", dest_to_rob_bus); end
    endtask

    task automatic test_lookup();
        alloc(NORMAL, 5'd8, 32'h400, 32'h404);
        qj = 5'd4; qk = 5'd0;
        wb_dest[1] = 5'd4; wb_value[1] = 32'h55;
        #1;
        checks++; if (valid_of_vj !== 1'b1 || vj !== 32'h55) begin errors++; $display("FAIL lk_lane1: got %0b/%0h expected 1/55", valid_of_vj, vj); end
        checks++; if (valid_of_vk !== 1'b0 || vk !== 32'h0) begin errors++; $display("FAIL lk_q_zero: got %0b/%0h expected 0/0", valid_of_vk, vk); end
        wb_dest[0] = 5'd4; wb_value[0] = 32'hAA;
        #1;
        checks++; if (valid_of_vj !== 1'b1 || vj !== 32'hAA) begin errors++; $display("FAIL lk_lane0_wins: got %0b/%0h expected 1/aa", valid_of_vj, vj); end
        wb_dest[0] = 5'd0; wb_value[0] = 32'h0; qk = 5'd5;
        #1;
        checks++; if (valid_of_vk !== 1'b0) begin errors++; $display("FAIL lk_pending: got %0b expected 0", valid_of_vk); end
        tick();
        wb_dest = '0;
        wb_dest[0] = 5'd4; wb_value[0] = 32'h77;
        #1;
        checks++; if (valid_of_vj !== 1'b1 || vj !== 32'h55) begin errors++; $display("FAIL lk_entry_priority: got %0b/%0h expected 1/55", valid_of_vj, vj); end
        wb_dest = '0; wb_value = '0;
        tick();
        checks++; if (commit_dest0 !== 5'd4 || commit_value0 !== 32'h55) begin errors++; $display("FAIL lk_commit: got %0d/%0h expected 4/55", commit_dest0, commit_value0); end
        checks++; if (valid_of_vj !== 1'b0) begin errors++; $display("FAIL lk_after_retire: got %0b expected 0", valid_of_vj); end
        qj = '0; qk = '0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) alloc(NORMAL, 5'(i + 1), 32'h500 + 32'(i * 4), 32'h504 + 32'(i * 4));
        wb_dest[0] = 5'd5; wb_value[0] = 32'h5A;
        tick();
        wb_dest = '0;
        tick();
        checks++; if (commit_dest0 !== 5'd5 || commit_value0 !== 32'h5A) begin errors++; $display("FAIL ar_pre_commit: got %0d/%0h expected 5/5a", commit_dest0, commit_value0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (commit_dest0 !== 5'd0 || commit_value0 !== 32'h0) begin errors++; $display("FAIL ar_outputs: got %0d/%0h expected 0/0", commit_dest0, commit_value0); end
        checks++; if (is_full !== 1'b0) begin errors++; $display("FAIL ar_is_full: got %0b expected 0", is_full); end
        checks++; if (dest_to_issuer !== 5'd1) begin errors++; $display("FAIL ar_tail: got %0d expected 1", dest_to_issuer); end
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rdy = 1'b1;
        test_reset();
        test_dual_commit();
        test_full_wrap();
        test_branch_mispredict();
        test_store();
        test_load_release();
        test_lookup();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
